// File: rtl/mem_column_loader.sv
// rtl/mem_column_loader.sv - packs a column-major word stream into per-column bank writes (option: MEM_COLUMN_LOADER_RESTART_EN)
//
// clk, rst_l          : clock, synchronous active-low reset
// start               : begin a frame (sampled in IDLE)
// in_valid/in_data    : stream word, column-major, row 0 first
// in_ready            : word accepted on edges where in_valid && in_ready
// we/write_data       : one-cycle write of a packed column (element i = row i)
// addr_write          : column index of the write, zero-extended
// busy/done           : frame in progress / one-cycle pulse after last write
module mem_column_loader #(
    parameter int IMG_ROWS = 4,
    parameter int IMG_COLS = 4
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [31:0]              in_data,
    output logic                     in_ready,
    output logic                     we,
    output logic [IMG_ROWS-1:0][31:0] write_data,
    output logic [31:0]              addr_write,
    output logic                     busy,
    output logic                     done
);

    localparam int RW = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
    localparam int CW = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(IMG_ROWS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_COLS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                    state;
    logic [RW-1:0]             row;
    logic [CW-1:0]             col;
    logic [IMG_ROWS-1:0][31:0] col_buf;
    logic [IMG_ROWS-1:0][31:0] col_vec;

    // The last row never lands in col_buf; it goes straight into the write vector.
    always_comb begin
        col_vec = col_buf;
        col_vec[IMG_ROWS-1] = in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            col_buf    <= '0;
            in_ready   <= 1'b0;
            we         <= 1'b0;
            write_data <= '0;
            addr_write <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        row      <= '0;
                        col      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
`ifdef MEM_COLUMN_LOADER_RESTART_EN
                    if (start) begin
                        // Restart drops any partial column and a word offered on this edge.
                        row <= '0;
                        col <= '0;
                    end else
`endif
                    if (in_valid) begin
                        if (row == R_LAST) begin
                            write_data <= col_vec;
                            addr_write <= 32'(col);
                            we         <= 1'b1;
                            row        <= '0;
                            if (col == C_LAST) begin
                                state    <= FLUSH;
                                in_ready <= 1'b0;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end else begin
                            col_buf[row] <= in_data;
                            row          <= row + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_column_loader.sv
// tb/tb_mem_column_loader.sv - directed self-checking bench for mem_column_loader
module tb_mem_column_loader;

    localparam int R = 4;
    localparam int C = 4;

    logic             clk = 1'b0;
    logic             rst_l;
    logic             start;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic             we;
    logic [R-1:0][31:0] write_data;
    logic [31:0]      addr_write;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    mem_column_loader #(.IMG_ROWS(R), .IMG_COLS(C)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .we         (we),
        .write_data (write_data),
        .addr_write (addr_write),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected packed column for rows holding b, b+1, b+2, b+3 (row 0 in the low word).
    function automatic logic [127:0] colv(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    // Streams 16 words base+k with in_valid held high; checks every write and the done pulse.
    task automatic run_frame(input string tag, input logic [31:0] base);
        for (int k = 0; k < R * C; k++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(k);
            tick();
            chk({tag, "_we"}, 128'(we), 128'(k % R == R - 1));
            if (k % R == R - 1) begin
                chk({tag, "_addr"}, 128'(addr_write), 128'(k / R));
                chk({tag, "_data"}, write_data, colv(base + 32'(R * (k / R))));
            end
        end
        in_valid = 1'b0;
        chk({tag, "_flush_ready"}, 128'(in_ready), 128'(0));
        chk({tag, "_flush_busy"}, 128'(busy), 128'(1));
        tick();
        chk({tag, "_done"}, 128'(done), 128'(1));
        chk({tag, "_done_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done_we"}, 128'(we), 128'(0));
    endtask

    initial begin
        rst_l    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;

        // Reset, then stream offered without start
        tick();
        tick();
        rst_l = 1'b1;
        tick();
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_we", 128'(we), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_addr", 128'(addr_write), 128'(0));
        chk("rst_data", write_data, 128'(0));
        tick();
        chk("idle_we", 128'(we), 128'(0));
        in_valid = 1'b0;

        // Full 4x4 frame, continuous valid
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("f1_ready", 128'(in_ready), 128'(1));
        chk("f1_busy", 128'(busy), 128'(1));
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(k);
            tick();
            chk("f1_we", 128'(we), 128'(k % 4 == 3));
            if (k == 3) begin
                chk("f1_col0_addr", 128'(addr_write), 128'(0));
                chk("f1_col0_data", write_data, 128'h00000103_00000102_00000101_00000100);
                chk("f1_col0_ready", 128'(in_ready), 128'(1));
            end
            if (k == 4) begin
                chk("f1_hold_addr", 128'(addr_write), 128'(0));
                chk("f1_hold_data", write_data, 128'h00000103_00000102_00000101_00000100);
            end
            if (k == 15) begin
                chk("f1_col3_addr", 128'(addr_write), 128'(3));
                chk("f1_col3_data", write_data, 128'h0000010F_0000010E_0000010D_0000010C);
            end
        end
        in_valid = 1'b0;
        chk("f1_flush_ready", 128'(in_ready), 128'(0));
        chk("f1_flush_done", 128'(done), 128'(0));
        tick();
        chk("f1_done", 128'(done), 128'(1));
        chk("f1_done_busy", 128'(busy), 128'(0));
        tick();
        chk("f1_done_once", 128'(done), 128'(0));

        // Source backpressure within column 1
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h200 + 32'(k);
            tick();
        end
        chk("bp_col0_we", 128'(we), 128'(1));
        in_valid = 1'b1; in_data = 32'h204; tick();
        in_valid = 1'b0; in_data = 32'hBAD0; tick();
        chk("bp_gap_we", 128'(we), 128'(0));
        in_valid = 1'b1; in_data = 32'h205; tick();
        in_valid = 1'b0; in_data = 32'hBAD1; tick();
        in_valid = 1'b1; in_data = 32'h206; tick();
        chk("bp_3rd_we", 128'(we), 128'(0));
        in_valid = 1'b1; in_data = 32'h207; tick();
        chk("bp_col1_we", 128'(we), 128'(1));
        chk("bp_col1_addr", 128'(addr_write), 128'(1));
        chk("bp_col1_data", write_data, 128'h00000207_00000206_00000205_00000204);
        for (int k = 8; k < 16; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h200 + 32'(k);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_col3_addr", 128'(addr_write), 128'(3));
        tick();
        chk("bp_done", 128'(done), 128'(1));
        tick();

        // Reset after six accepted words
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h300 + 32'(k);
            tick();
        end
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        chk("mr_we", 128'(we), 128'(0));
        chk("mr_busy", 128'(busy), 128'(0));
        chk("mr_ready", 128'(in_ready), 128'(0));
        chk("mr_data", write_data, 128'(0));
        tick();
        tick();
        chk("mr_idle_we", 128'(we), 128'(0));
        in_valid = 1'b0;

        // Fresh frame, then back-to-back frame started during done
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame("f2", 32'h400);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_ready", 128'(in_ready), 128'(1));
        chk("b2b_done_clear", 128'(done), 128'(0));
        run_frame("f3", 32'h500);
        tick();

`ifdef MEM_COLUMN_LOADER_RESTART_EN
        // Restart mid-frame: word on the restart edge is dropped
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h600 + 32'(k);
            tick();
        end
        chk("rs_col0_we", 128'(we), 128'(1));
        chk("rs_col0_data", write_data, 128'h00000603_00000602_00000601_00000600);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h604;
        tick();
        start = 1'b0;
        chk("rs_edge_we", 128'(we), 128'(0));
        chk("rs_edge_ready", 128'(in_ready), 128'(1));
        run_frame("rs", 32'h610);
        tick();
        chk("rs_done_once", 128'(done), 128'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_column_loader.md
Name: mem_column_loader

Overview:
- Writer-side front end for the column-organised image memory bank (IMG_ROWS parallel SRAMs, each IMG_COLS deep, 32-bit words).
- Accepts a column-major pixel stream over a valid/ready handshake and packs IMG_ROWS consecutive words into one column vector.
- Issues one full-width write per column with the column index as the write address.
- Drives the bank's `we`, `write_data` and `addr_write` inputs directly.

Parameters:
- IMG_ROWS, 4, number of rows; words per column; width of the write vector; must be >= 1.
- IMG_COLS, 4, number of columns per frame; write address range 0..IMG_COLS-1; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_l  input  1  synchronous active-low reset.
- start  input  1  begin a frame; sampled only in IDLE.
- in_valid  input  1  stream word valid.
- in_data  input  32  stream word: pixel (row r, column c), column-major order, row 0 first.
- in_ready  output  1  loader can accept a word.
- we  output  1  memory write enable, one cycle per completed column.
- write_data  output  [IMG_ROWS-1:0][31:0]  packed column; element i = row i.
- addr_write  output  32  column index, zero-extended.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after the final column write.

Behaviour:
- Interface: one clock, clk. Reset rst_l is synchronous and active-low.
- Reset (rst_l=0 at a clock edge):
  - state=IDLE; we=0, done=0, busy=0, in_ready=0.
  - write_data=0, addr_write=0; row and column counters=0.
  - Reset overrides all other inputs, including mid-frame. A partial column is discarded and no write is issued.
- States:
  - IDLE: in_ready=0, busy=0. start=1 -> LOAD with counters cleared.
  - LOAD: in_ready=1, busy=1. A word is accepted on an edge where in_valid && in_ready.
  - FLUSH: in_ready=0, busy=1. Lasts exactly one cycle, then -> IDLE with done=1 for that next cycle.
- Acceptance in LOAD, row counter r < IMG_ROWS-1:
  - Word stored in column buffer slot r; r increments.
- Acceptance in LOAD, r == IMG_ROWS-1 (column complete):
  - On that edge: write_data <= {incoming word at slot r, buffered slots 0..r-1}; addr_write <= c; we <= 1; r <= 0.
  - If c < IMG_COLS-1: c increments and the state stays LOAD. in_ready stays 1, so the next column streams with no bubble while we is high.
  - If c == IMG_COLS-1: state -> FLUSH. we is high during the FLUSH cycle.
- Write latency: we is high the cycle immediately after the edge that accepted the column's last word, for exactly one cycle.
- When we=0, write_data and addr_write hold their last values.
- done: asserted the cycle after FLUSH (state is IDLE), for exactly one cycle. It is 2 cycles after the final word was accepted.
- start during the done cycle is accepted and begins a new frame.
- start outside IDLE is ignored (see optional feature).
- in_valid while in_ready=0 is not consumed. The word must be held by the source.
- IMG_ROWS=1: every accepted word produces a write.
- IMG_COLS=1: the frame completes after one column.
- Counter widths: $clog2 of the parameter, minimum 1 bit. Wrap-around is never used; counters are explicitly cleared.

Optional Feature:
- Macro: MEM_COLUMN_LOADER_RESTART_EN.
- Defined: start=1 in LOAD restarts the frame on that edge.
  - r and c are cleared, buffered partial-column words are discarded, state stays LOAD.
  - A word accepted on the same edge is dropped.
  - A we already scheduled for a column completed on the previous edge still issues.
  - start in FLUSH is ignored.
- Undefined: start is ignored in LOAD and FLUSH, and the frame always runs to completion.

Test Plan:
- Reset then idle: rst_l=0 two cycles, release, in_valid=1 without start -> in_ready=0, we=0, done=0, busy=0, addr_write=0, write_data all 0.
- Full 4x4 frame, in_valid continuous, data 0x100+k (k=0..15) -> we pulses 4 times, 4 cycles apart.
  - Column 0 write: addr_write=0, write_data[0..3]=0x100..0x103.
  - Column 3 write: addr_write=3, write_data[0..3]=0x10C..0x10F.
  - done one cycle exactly 2 cycles after the 16th accept; busy low with done.
- Backpressure from source: in_valid toggled 1,0,1,0 within column 1 -> only valid cycles counted. Column 1 write occurs the cycle after its 4th accept, with the correct data ordering.
- Reset mid-frame after 6 words -> no further we. After restart, a fresh frame writes addr 0 first with the new data.
- Back-to-back frames: start asserted during the done cycle -> in_ready=1 the next cycle; second frame writes addr 0..3 correctly.
- With MEM_COLUMN_LOADER_RESTART_EN: start after 5 accepts -> column 0 write (from the 4th accept) still issues. The next 16 words produce writes at addr 0..3, the 5th word is absent from all writes, and done fires once.
